// File: rtl/oka_mul_arbiter.sv
// ---------------------------------------------------------------------------
// oka_mul_arbiter
//
// Shares one external 8-bit multiplier between two requesters. Operand pairs
// are accepted one at a time with round-robin arbitration on ties. The
// operands are launched on mul_a/mul_b, the product is captured from mul_y
// MUL_LAT cycles later, and the product is presented on the response port
// until the consumer takes it.
//
// Parameters
//   MUL_LAT     cycles from operand launch to product capture (1..4)
//
// Ports
//   clk         sole clock, rising edge
//   rst_n       asynchronous active-low reset
//   req0_valid  requester 0 has an operand pair
//   req0_ready  requester 0 pair is accepted this cycle (with req0_valid)
//   req0_a/b    requester 0 operands, unsigned 8-bit
//   req1_*      same as req0_* for requester 1
//   mul_a/b     operands held toward the shared multiplier
//   mul_y       16-bit product returned by the shared multiplier
//   rsp_valid   rsp_p / rsp_id are valid
//   rsp_ready   consumer takes the response
//   rsp_id      requester index that owns rsp_p
//   rsp_p       captured product
//   busy        high whenever a transaction is in flight
//   done_cnt    completed responses, wraps 255 -> 0
// ---------------------------------------------------------------------------
module oka_mul_arbiter #(
    parameter int unsigned MUL_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [7:0]  req0_a,
    input  logic [7:0]  req0_b,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [7:0]  req1_a,
    input  logic [7:0]  req1_b,

    output logic [7:0]  mul_a,
    output logic [7:0]  mul_b,
    input  logic [15:0] mul_y,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [15:0] rsp_p,

    output logic        busy,
    output logic [7:0]  done_cnt
);

    localparam logic [2:0] LAT = 3'(MUL_LAT);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        RSP
    } state_t;

    state_t     state;
    logic       last_grant;
    logic       owner;
    logic [2:0] cnt;

    logic       grant_vld;
    logic       grant_id;
    logic       accept;

    // Arbitration: a lone requester wins outright; on a tie the requester
    // that did not win last time is chosen.
    always_comb begin
        grant_vld = req0_valid | req1_valid;
        grant_id  = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant;
        end else if (req1_valid) begin
            grant_id = 1'b1;
        end
    end

    // Ready is gated by rst_n so neither requester sees a handshake while
    // the block is held in reset.
    always_comb begin
        req0_ready = rst_n && (state == IDLE) && grant_vld && !grant_id;
        req1_ready = rst_n && (state == IDLE) && grant_vld &&  grant_id;
        accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            cnt        <= '0;
            mul_a      <= '0;
            mul_b      <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_p      <= '0;
            done_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mul_a      <= grant_id ? req1_a : req0_a;
                        mul_b      <= grant_id ? req1_b : req0_b;
                        owner      <= grant_id;
                        last_grant <= grant_id;
                        cnt        <= LAT;
                        state      <= MUL;
                    end
                end

                // The capture edge is the one on which cnt is 1, so the
                // response appears exactly MUL_LAT edges after accept.
                MUL: begin
                    if (cnt == 3'd1) begin
                        rsp_p     <= mul_y;
                        rsp_id    <= owner;
                        rsp_valid <= 1'b1;
                        cnt       <= '0;
                        state     <= RSP;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end

                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        done_cnt  <= done_cnt + 8'd1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_oka_mul_arbiter.sv
module tb_oka_mul_arbiter;

    // Instance 0 runs with MUL_LAT=1, instance 1 with MUL_LAT=3.
    logic        clk;
    logic        rst_n      [2];
    logic        req0_valid [2];
    logic        req0_ready [2];
    logic [7:0]  req0_a     [2];
    logic [7:0]  req0_b     [2];
    logic        req1_valid [2];
    logic        req1_ready [2];
    logic [7:0]  req1_a     [2];
    logic [7:0]  req1_b     [2];
    logic [7:0]  mul_a      [2];
    logic [7:0]  mul_b      [2];
    logic [15:0] mul_y      [2];
    logic        rsp_valid  [2];
    logic        rsp_ready  [2];
    logic        rsp_id     [2];
    logic [15:0] rsp_p      [2];
    logic        busy       [2];
    logic [7:0]  done_cnt   [2];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model state per instance
    logic m_lg     [2];
    int   m_done   [2];
    int   last_acc [2];

    oka_mul_arbiter #(.MUL_LAT(1)) dut_l1 (
        .clk(clk), .rst_n(rst_n[0]),
        .req0_valid(req0_valid[0]), .req0_ready(req0_ready[0]),
        .req0_a(req0_a[0]), .req0_b(req0_b[0]),
        .req1_valid(req1_valid[0]), .req1_ready(req1_ready[0]),
        .req1_a(req1_a[0]), .req1_b(req1_b[0]),
        .mul_a(mul_a[0]), .mul_b(mul_b[0]), .mul_y(mul_y[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_id(rsp_id[0]), .rsp_p(rsp_p[0]),
        .busy(busy[0]), .done_cnt(done_cnt[0])
    );

    oka_mul_arbiter #(.MUL_LAT(3)) dut_l3 (
        .clk(clk), .rst_n(rst_n[1]),
        .req0_valid(req0_valid[1]), .req0_ready(req0_ready[1]),
        .req0_a(req0_a[1]), .req0_b(req0_b[1]),
        .req1_valid(req1_valid[1]), .req1_ready(req1_ready[1]),
        .req1_a(req1_a[1]), .req1_b(req1_b[1]),
        .mul_a(mul_a[1]), .mul_b(mul_b[1]), .mul_y(mul_y[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_id(rsp_id[1]), .rsp_p(rsp_p[1]),
        .busy(busy[1]), .done_cnt(done_cnt[1])
    );

    // Shared multiplier stand-ins
    assign mul_y[0] = 16'(mul_a[0]) * 16'(mul_b[0]);
    assign mul_y[1] = 16'(mul_a[1]) * 16'(mul_b[1]);

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic checkv(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checkv(tag, {31'd0, obs}, {31'd0, exp});
    endtask

    // Asserts reset mid-cycle, checks the asynchronous reset values, releases.
    task automatic reset_dut(input int d);
        req0_valid[d] = 1'b1;
        req1_valid[d] = 1'b1;
        rst_n[d] = 1'b0;
        #1;
        check1("rst_busy",      busy[d],       1'b0);
        check1("rst_rsp_valid", rsp_valid[d],  1'b0);
        check1("rst_rsp_id",    rsp_id[d],     1'b0);
        checkv("rst_rsp_p",     32'(rsp_p[d]), 32'd0);
        checkv("rst_mul_a",     32'(mul_a[d]), 32'd0);
        checkv("rst_mul_b",     32'(mul_b[d]), 32'd0);
        checkv("rst_done_cnt",  32'(done_cnt[d]), 32'd0);
        check1("rst_ready0",    req0_ready[d], 1'b0);
        check1("rst_ready1",    req1_ready[d], 1'b0);
        req0_valid[d] = 1'b0;
        req1_valid[d] = 1'b0;
        #2;
        rst_n[d] = 1'b1;
        m_lg[d]     = 1'b1;
        m_done[d]   = 0;
        last_acc[d] = 0;
        @(posedge clk); #1;
    endtask

    // One full transaction: offer, accept, wait for response, hold, retire.
    // Starts and ends 1 time unit after a rising edge with the DUT idle.
    task automatic run_txn(input int d, input logic v0, input logic v1,
                           input logic [7:0] a0, input logic [7:0] b0,
                           input logic [7:0] a1, input logic [7:0] b1,
                           input int hold, input bit spc);
        logic        g;
        logic [7:0]  ea, eb;
        logic [15:0] ep;
        int          k, acc;

        rsp_ready[d]  = (hold == 0);
        req0_valid[d] = v0; req0_a[d] = a0; req0_b[d] = b0;
        req1_valid[d] = v1; req1_a[d] = a1; req1_b[d] = b1;
        #1;
        g  = (v0 && v1) ? ~m_lg[d] : v1;
        ea = g ? a1 : a0;
        eb = g ? b1 : b0;
        ep = 16'(ea) * 16'(eb);
        check1("ready0", req0_ready[d], v0 && !g);
        check1("ready1", req1_ready[d], v1 &&  g);

        @(posedge clk); #1;
        acc = cyc;
        if (spc) checkv("spacing", 32'(acc - last_acc[d]), 32'(lat_of(d) + 2));
        last_acc[d] = acc;
        m_lg[d] = g;
        checkv("mul_a", 32'(mul_a[d]), 32'(ea));
        checkv("mul_b", 32'(mul_b[d]), 32'(eb));
        check1("busy_acc", busy[d], 1'b1);
        check1("ready0_busy", req0_ready[d], 1'b0);
        check1("ready1_busy", req1_ready[d], 1'b0);

        // Requester inputs after accept must be ignored.
        req0_a[d] = ~a0; req1_a[d] = ~a1;

        k = 0;
        while (!rsp_valid[d] && k < 8) begin
            @(posedge clk); #1;
            k++;
        end
        checkv("latency", 32'(k), 32'(lat_of(d)));
        checkv("rsp_p",   32'(rsp_p[d]), 32'(ep));
        check1("rsp_id",  rsp_id[d], g);
        checkv("mul_a_hold", 32'(mul_a[d]), 32'(ea));

        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check1("hold_valid", rsp_valid[d], 1'b1);
            checkv("hold_p",     32'(rsp_p[d]), 32'(ep));
            check1("hold_id",    rsp_id[d], g);
        end
        rsp_ready[d] = 1'b1;
        @(posedge clk); #1;
        m_done[d]++;
        req0_valid[d] = 1'b0;
        req1_valid[d] = 1'b0;
        check1("retire_valid", rsp_valid[d], 1'b0);
        check1("retire_busy",  busy[d], 1'b0);
        checkv("done_cnt", 32'(done_cnt[d]), 32'(m_done[d] % 256));
        checkv("mul_a_after", 32'(mul_a[d]), 32'(ea));
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0;
            req0_valid[d] = 1'b0; req0_a[d] = '0; req0_b[d] = '0;
            req1_valid[d] = 1'b0; req1_a[d] = '0; req1_b[d] = '0;
            rsp_ready[d] = 1'b0;
            m_lg[d] = 1'b1; m_done[d] = 0; last_acc[d] = 0;
        end
        #1;
        reset_dut(0);
        reset_dut(1);

        // Nobody requesting: stays idle.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check1("idle_busy",   busy[0], 1'b0);
            check1("idle_ready0", req0_ready[0], 1'b0);
            check1("idle_ready1", req1_ready[0], 1'b0);
        end

        // Single requester 0, MUL_LAT=1.
        run_txn(0, 1'b1, 1'b0, 8'd250, 8'd255, 8'd0, 8'd0, 0, 1'b0);

        // Continuous tie: alternating grants from a fresh reset.
        reset_dut(0);
        for (int r = 0; r < 4; r++) begin
            run_txn(0, 1'b1, 1'b1, 8'd255, 8'd255, 8'd3, 8'd7, 0, r > 0);
            check1("tie_alternate", rsp_id[0], (r % 2) == 1);
        end

        // MUL_LAT=3, requester 1, consumer stalls 5 cycles.
        run_txn(1, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 8'd200, 5, 1'b0);

        // Reset while in MUL: transaction discarded.
        rsp_ready[1]  = 1'b1;
        req1_valid[1] = 1'b1; req1_a[1] = 8'd9; req1_b[1] = 8'd9;
        @(posedge clk); #1;
        req1_valid[1] = 1'b0;
        check1("mid_mul_busy", busy[1], 1'b1);
        reset_dut(1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check1("post_rst_no_rsp", rsp_valid[1], 1'b0);
            checkv("post_rst_done", 32'(done_cnt[1]), 32'd0);
        end
        run_txn(1, 1'b1, 1'b1, 8'd17, 8'd19, 8'd23, 8'd29, 0, 1'b0);
        check1("post_rst_tie_grant0", rsp_id[1], 1'b0);

        // 256 back-to-back transactions, done_cnt wraps.
        reset_dut(0);
        for (int i = 0; i < 256; i++) begin
            run_txn(0, (i % 2) == 0, (i % 2) == 1,
                    8'(i), 8'(i + 1), 8'(i), 8'(i + 1), 0, i > 0);
        end
        checkv("wrap_done_cnt", 32'(done_cnt[0]), 32'd0);

        // Randomized traffic on both instances.
        for (int n = 0; n < 60; n++) begin
            int d, pat;
            d   = int'($urandom_range(0, 1));
            pat = int'($urandom_range(1, 3));
            run_txn(d, pat[0], pat[1],
                    8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                    int'($urandom_range(0, 3)), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/oka_mul_arbiter.md
OKA_MUL_ARBITER -- requirements
Module: oka_mul_arbiter

Interface
REQ-001 Parameter MUL_LAT, default 1: cycles from operand launch to product capture; legal range 1..4.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-004 req0_valid  input  1  requester 0 has an operand pair.
REQ-005 req0_ready  output  1  requester 0 operands accepted this cycle when high with req0_valid.
REQ-006 req0_a, req0_b  input  8 each  requester 0 operands, unsigned.
REQ-007 req1_valid, req1_ready, req1_a, req1_b  same as REQ-004..006 for requester 1.
REQ-008 mul_a, mul_b  output  8 each  operands driven to the shared 8-bit Karatsuba multiplier.
REQ-009 mul_y  input  16  product returned by the shared multiplier; full 16-bit width, no truncation.
REQ-010 rsp_valid  output  1  rsp_p and rsp_id are valid.
REQ-011 rsp_ready  input  1  consumer takes the response.
REQ-012 rsp_id  output  1  requester index owning rsp_p.
REQ-013 rsp_p  output  16  captured product.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 done_cnt  output  8  count of completed responses, wraps 255->0.

Function
REQ-016 FSM states: IDLE, MUL, RSP; one transaction in flight at most.
REQ-017 IDLE: grant = only valid requester; if both valid, requester not equal to last_grant; if none valid, no grant.
REQ-018 reqN_ready = (state==IDLE) and grant==N; combinational; never both high.
REQ-019 Accept = reqN_valid and reqN_ready: latch reqN_a/reqN_b onto mul_a/mul_b, latch N as owner, last_grant<=N, cnt<=MUL_LAT, go MUL.
REQ-020 mul_a/mul_b hold stable from accept edge until next accept; unchanged in MUL and RSP.
REQ-021 MUL: cnt decrements each cycle; on edge where cnt==1, rsp_p<=mul_y, rsp_id<=owner, rsp_valid<=1, go RSP.
REQ-022 Latency: rsp_valid rises exactly MUL_LAT clock edges after the accept edge.
REQ-023 RSP: rsp_valid, rsp_p, rsp_id held stable while rsp_ready low (no drop, no change).
REQ-024 RSP with rsp_ready high: rsp_valid<=0, done_cnt<=done_cnt+1 (mod 256), go IDLE; no accept in that same cycle.
REQ-025 Minimum spacing between accepts: MUL_LAT+2 cycles (rsp_ready held high).
REQ-026 Requester deasserting valid while not granted: no effect; requester valid/operands after accept: ignored.
REQ-027 rsp_p = a*b exactly as returned on mul_y; block performs no arithmetic on the product.

Reset
REQ-028 rst_n low: state=IDLE, mul_a=mul_b=0, rsp_valid=0, rsp_p=0, rsp_id=0, done_cnt=0, last_grant=1, cnt=0, immediately (no clock required).
REQ-029 Reset mid-MUL or mid-RSP: transaction discarded, no response emitted, done_cnt not incremented.
REQ-030 First tie after reset grants requester 0; reqN_ready low while rst_n low.

Verification
REQ-031 MUL_LAT=1, req0 a=250 b=255, rsp_ready=1 -> req0_ready high in accept cycle; rsp_valid one edge later, rsp_p=63750 (0xF906), rsp_id=0, done_cnt=1.
REQ-032 Both valid continuously, req0 a=255 b=255, req1 a=3 b=7 -> grants alternate 0,1,0,1; responses 65025 id0, 21 id1, repeated; never both ready.
REQ-033 MUL_LAT=3, req1 a=0 b=200, rsp_ready low 5 cycles -> rsp_valid at accept+3 edges, rsp_p=0 id=1 stable all 5 cycles, IDLE after rsp_ready.
REQ-034 rst_n pulsed low while in MUL -> outputs to reset values asynchronously, no rsp_valid, next tie grants requester 0.
REQ-035 256 back-to-back transactions a=i b=i+1 -> every rsp_p correct, done_cnt wraps to 0, spacing MUL_LAT+2 cycles.
